// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
// Patterns are active-low segment bits {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;

  // Code stored for any segment pattern that is not a legal decimal digit.
  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  // Frame assembly states.
  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } frame_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low seven-segment pattern to a decimal digit.
// Unrecognised patterns yield the invalid code with err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       err
);

  // Look the pattern up among the ten legal digits; anything else is an error.
  always_comb begin
    value = DIGIT_INVALID;
    err   = 1'b0;
    case (seg)
      SEG_PAT_0: value = 4'd0;
      SEG_PAT_1: value = 4'd1;
      SEG_PAT_2: value = 4'd2;
      SEG_PAT_3: value = 4'd3;
      SEG_PAT_4: value = 4'd4;
      SEG_PAT_5: value = 4'd5;
      SEG_PAT_6: value = 4'd6;
      SEG_PAT_7: value = 4'd7;
      SEG_PAT_8: value = 4'd8;
      SEG_PAT_9: value = 4'd9;
      default: begin
        value = DIGIT_INVALID;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 4-digit active-low LED display and rebuilds a frame
// snapshot of the shown digits once every digit has been seen stable.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic [7:0]  anode_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  pattern_err,
  output logic [3:0]  dp_out,
  output logic        frame_done,
  output logic        stale
);

  localparam logic [7:0]  STABLE_VAL  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0][7:0] anode_sync;
  logic [SYNC_STAGES-1:0][7:0] seg_sync;
  logic [7:0]        anode_s;
  logic [7:0]        seg_s;

  logic              cand;
  logic [1:0]        cand_idx;
  logic              same;
  logic              capture;
  logic [7:0]        stab_cnt;
  logic [7:0]        stab_cnt_next;
  logic [1:0]        prev_idx;
  logic [7:0]        prev_seg;

  logic [3:0]        dec_value;
  logic              dec_err;

  logic [3:0][3:0]   work_val;
  logic [3:0]        work_err;
  logic [3:0]        work_dp;
  logic [3:0]        mask;
  logic [3:0]        mask_next;
  logic [3:0]        cap_bit;

  frame_state_t      state;
  frame_state_t      state_next;
  logic              publish;

  logic [15:0]       to_cnt;
  logic [15:0]       to_cnt_next;
  logic              timeout_hit;

  // Bring the asynchronous display lines into the clock domain; idle is all-ones.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      anode_sync <= '1;
      seg_sync   <= '1;
    end else begin
      anode_sync <= {anode_sync[SYNC_STAGES-2:0], anode_in};
      seg_sync   <= {seg_sync[SYNC_STAGES-2:0], seg_in};
    end
  end

  assign anode_s = anode_sync[SYNC_STAGES-1];
  assign seg_s   = seg_sync[SYNC_STAGES-1];

  // A sample is usable only when exactly one digit anode is low and the unused ones are high.
  always_comb begin
    cand     = 1'b0;
    cand_idx = 2'd0;
    if (anode_s[3:0] == 4'hF) begin
      case (anode_s[7:4])
        4'b1110: begin cand = 1'b1; cand_idx = 2'd0; end
        4'b1101: begin cand = 1'b1; cand_idx = 2'd1; end
        4'b1011: begin cand = 1'b1; cand_idx = 2'd2; end
        4'b0111: begin cand = 1'b1; cand_idx = 2'd3; end
        default: begin cand = 1'b0; cand_idx = 2'd0; end
      endcase
    end
  end

  // Stability counter: saturates at the threshold so a held sample captures only once.
  always_comb begin
    same          = cand && (stab_cnt != 8'd0) && (cand_idx == prev_idx) && (seg_s == prev_seg);
    stab_cnt_next = 8'd0;
    capture       = 1'b0;
    if (cand) begin
      if (!same) begin
        stab_cnt_next = 8'd1;
      end else if (stab_cnt == STABLE_VAL) begin
        stab_cnt_next = stab_cnt;
      end else begin
        stab_cnt_next = stab_cnt + 8'd1;
      end
      capture = (stab_cnt_next == STABLE_VAL) && !(same && (stab_cnt == STABLE_VAL));
    end
  end

  // Remember the previous sample and its run length.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      stab_cnt <= 8'd0;
      prev_idx <= 2'd0;
      prev_seg <= 8'hFF;
    end else begin
      stab_cnt <= stab_cnt_next;
      prev_idx <= cand_idx;
      prev_seg <= seg_s;
    end
  end

  seg7_pattern_decode u_decode (
    .seg   (seg_s[6:0]),
    .value (dec_value),
    .err   (dec_err)
  );

  assign cap_bit   = capture ? (4'b0001 << cand_idx) : 4'b0000;
  assign mask_next = ((state == PUBLISH) ? 4'b0000 : mask) | cap_bit;

  // Working copy of each digit; a later capture of the same digit simply overwrites it.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      work_val <= {4{DIGIT_INVALID}};
      work_err <= 4'b0000;
      work_dp  <= 4'b0000;
      mask     <= 4'b0000;
    end else begin
      mask <= mask_next;
      if (capture) begin
        work_val[cand_idx] <= dec_value;
        work_err[cand_idx] <= dec_err;
        work_dp[cand_idx]  <= ~seg_s[7];
      end
    end
  end

  // Frame state register.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Publish as soon as every digit has been seen, counting a capture in this same cycle.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      COLLECT: begin
        if (mask_next == 4'b1111) begin
          state_next = PUBLISH;
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  assign to_cnt_next = publish ? 16'd0 :
                       ((to_cnt == TIMEOUT_VAL) ? to_cnt : to_cnt + 16'd1);
  assign timeout_hit = (to_cnt_next == TIMEOUT_VAL);

  // Snapshot outputs and staleness; a timeout withdraws validity until the next frame.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      digits      <= 16'hFFFF;
      digit_valid <= 4'b0000;
      pattern_err <= 4'b0000;
      dp_out      <= 4'b0000;
      frame_done  <= 1'b0;
      stale       <= 1'b0;
      to_cnt      <= 16'd0;
    end else begin
      frame_done <= publish;
      to_cnt     <= to_cnt_next;
      stale      <= publish ? 1'b0 : (stale | timeout_hit);
      if (publish) begin
        digits      <= work_val;
        digit_valid <= ~work_err;
        pattern_err <= work_err;
        dp_out      <= work_dp;
      end else if (timeout_hit) begin
        digit_valid <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: default, slow-stability and short-timeout instances
// share the same stimulus; each test checks only the instance it targets.
module tb_seg7_scan_decoder;

  logic        sysclock = 1'b0;
  logic        reset    = 1'b0;
  logic [7:0]  anode_in = 8'hFF;
  logic [7:0]  seg_in   = 8'hFF;

  logic [15:0] digits_a, digits_b, digits_c;
  logic [3:0]  valid_a, valid_b, valid_c;
  logic [3:0]  err_a, err_b, err_c;
  logic [3:0]  dp_a, dp_b, dp_c;
  logic        fd_a, fd_b, fd_c;
  logic        stale_a, stale_b, stale_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0][6:0] pat;
    logic [3:0]      dp_lit;
    logic [15:0]     exp_digits;
    logic [3:0]      exp_valid;
    logic [3:0]      exp_err;
    logic [3:0]      exp_dp;
  } vec_t;

  vec_t vecs [5];

  seg7_scan_decoder dut_a (
    .sysclock(sysclock), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
    .digits(digits_a), .digit_valid(valid_a), .pattern_err(err_a), .dp_out(dp_a),
    .frame_done(fd_a), .stale(stale_a)
  );

  seg7_scan_decoder #(.STABLE_CYCLES(3)) dut_b (
    .sysclock(sysclock), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
    .digits(digits_b), .digit_valid(valid_b), .pattern_err(err_b), .dp_out(dp_b),
    .frame_done(fd_b), .stale(stale_b)
  );

  seg7_scan_decoder #(.TIMEOUT_CYCLES(16)) dut_c (
    .sysclock(sysclock), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
    .digits(digits_c), .digit_valid(valid_c), .pattern_err(err_c), .dp_out(dp_c),
    .frame_done(fd_c), .stale(stale_c)
  );

  always #5 sysclock = ~sysclock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] anodeFor(input int idx);
    logic [7:0] a;
    a = 8'hFF;
    a[4+idx] = 1'b0;
    return a;
  endfunction

  function automatic logic [7:0] segFor(input logic [6:0] pat, input logic dp_lit);
    return {~dp_lit, pat};
  endfunction

  function automatic logic pickFrameDone(input int which);
    case (which)
      0: return fd_a;
      1: return fd_b;
      default: return fd_c;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic holdWatch(input logic [7:0] an, input logic [7:0] sg, input int cycles,
                           input int which, output int seen);
    seen     = 0;
    anode_in = an;
    seg_in   = sg;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sysclock);
      if (pickFrameDone(which)) seen++;
    end
  endtask

  task automatic finishFrame(input int idx, input logic [6:0] pat, input logic dp_lit,
                             input int hold, input int which, output int lat);
    lat      = 0;
    anode_in = anodeFor(idx);
    seg_in   = segFor(pat, dp_lit);
    for (int k = 1; k <= 12; k++) begin
      @(negedge sysclock);
      if (k == hold) begin
        anode_in = 8'hFF;
        seg_in   = 8'hFF;
      end
      if (pickFrameDone(which)) begin
        lat = k;
        break;
      end
    end
    anode_in = 8'hFF;
    seg_in   = 8'hFF;
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    int s;
    for (int i = 0; i < 3; i++) holdWatch(anodeFor(i), segFor(v.pat[i], v.dp_lit[i]), 1, 0, s);
    finishFrame(3, v.pat[3], v.dp_lit[3], 1, 0, lat);
  endtask

  task automatic doReset();
    anode_in = 8'hFF;
    seg_in   = 8'hFF;
    reset    = 1'b1;
    repeat (2) @(negedge sysclock);
    reset = 1'b0;
    @(negedge sysclock);
  endtask

  initial begin
    int lat;
    int s;
    int seen;

    vecs[0].pat = {7'h10, 7'h19, 7'h79, 7'h30}; vecs[0].dp_lit = 4'b0000;
    vecs[0].exp_digits = 16'h9413; vecs[0].exp_valid = 4'hF; vecs[0].exp_err = 4'h0; vecs[0].exp_dp = 4'h0;
    vecs[1].pat = {7'h00, 7'h7F, 7'h78, 7'h40}; vecs[1].dp_lit = 4'b0000;
    vecs[1].exp_digits = 16'h8F70; vecs[1].exp_valid = 4'b1011; vecs[1].exp_err = 4'b0100; vecs[1].exp_dp = 4'h0;
    vecs[2].pat = {7'h79, 7'h24, 7'h02, 7'h12}; vecs[2].dp_lit = 4'b1010;
    vecs[2].exp_digits = 16'h1265; vecs[2].exp_valid = 4'hF; vecs[2].exp_err = 4'h0; vecs[2].exp_dp = 4'b1010;
    vecs[3].pat = {7'h11, 7'h30, 7'h10, 7'h7E}; vecs[3].dp_lit = 4'b0000;
    vecs[3].exp_digits = 16'hF39F; vecs[3].exp_valid = 4'b0110; vecs[3].exp_err = 4'b1001; vecs[3].exp_dp = 4'h0;
    vecs[4].pat = {7'h00, 7'h00, 7'h00, 7'h00}; vecs[4].dp_lit = 4'b1111;
    vecs[4].exp_digits = 16'h8888; vecs[4].exp_valid = 4'hF; vecs[4].exp_err = 4'h0; vecs[4].exp_dp = 4'hF;

    // Reset values, observed before any clock edge.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_digits", digits_a, 16'hFFFF);
    checkOutput("rst_valid", valid_a, 4'h0);
    checkOutput("rst_err", err_a, 4'h0);
    checkOutput("rst_dp", dp_a, 4'h0);
    checkOutput("rst_frame_done", fd_a, 1'b0);
    checkOutput("rst_stale", stale_a, 1'b0);
    repeat (2) @(negedge sysclock);
    reset = 1'b0;
    @(negedge sysclock);

    // Table-driven frames, one cycle per digit.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v], lat);
      checkOutput($sformatf("vec%0d_latency", v), lat, 4);
      checkOutput($sformatf("vec%0d_digits", v), digits_a, vecs[v].exp_digits);
      checkOutput($sformatf("vec%0d_valid", v), valid_a, vecs[v].exp_valid);
      checkOutput($sformatf("vec%0d_err", v), err_a, vecs[v].exp_err);
      checkOutput($sformatf("vec%0d_dp", v), dp_a, vecs[v].exp_dp);
      @(negedge sysclock);
      checkOutput($sformatf("vec%0d_pulse_width", v), fd_a, 1'b0);
      @(negedge sysclock);
    end

    // Multiple or misplaced anodes must be ignored.
    doReset();
    seen = 0;
    holdWatch(anodeFor(0), segFor(7'h24, 1'b0), 1, 0, s); seen += s;
    holdWatch(anodeFor(1), segFor(7'h40, 1'b0), 1, 0, s); seen += s;
    holdWatch(anodeFor(2), segFor(7'h12, 1'b0), 1, 0, s); seen += s;
    holdWatch(8'h3F, 8'h80, 10, 0, s); seen += s;
    holdWatch(8'h7E, 8'h99, 5, 0, s); seen += s;
    holdWatch(8'hFF, 8'hFF, 4, 0, s); seen += s;
    checkOutput("multi_anode_no_frame", seen, 0);
    finishFrame(3, 7'h19, 1'b0, 1, 0, lat);
    checkOutput("multi_anode_latency", lat, 4);
    checkOutput("multi_anode_digits", digits_a, 16'h4502);

    // Reset in the middle of a frame discards the partial frame.
    holdWatch(anodeFor(0), segFor(7'h79, 1'b0), 1, 0, s);
    holdWatch(anodeFor(1), segFor(7'h24, 1'b0), 1, 0, s);
    holdWatch(anodeFor(2), segFor(7'h30, 1'b0), 1, 0, s);
    anode_in = 8'hFF;
    seg_in   = 8'hFF;
    reset    = 1'b1;
    #1;
    checkOutput("midrst_digits", digits_a, 16'hFFFF);
    checkOutput("midrst_valid", valid_a, 4'h0);
    checkOutput("midrst_err", err_a, 4'h0);
    checkOutput("midrst_dp", dp_a, 4'h0);
    checkOutput("midrst_frame_done", fd_a, 1'b0);
    checkOutput("midrst_stale", stale_a, 1'b0);
    repeat (2) @(negedge sysclock);
    reset = 1'b0;
    @(negedge sysclock);
    seen = 0;
    holdWatch(anodeFor(3), segFor(7'h02, 1'b0), 1, 0, s); seen += s;
    holdWatch(8'hFF, 8'hFF, 8, 0, s); seen += s;
    checkOutput("midrst_no_early_frame", seen, 0);
    holdWatch(anodeFor(0), segFor(7'h78, 1'b0), 1, 0, s);
    holdWatch(anodeFor(1), segFor(7'h00, 1'b0), 1, 0, s);
    finishFrame(2, 7'h10, 1'b0, 1, 0, lat);
    checkOutput("midrst_latency", lat, 4);
    checkOutput("midrst_digits", digits_a, 16'h6987);

    // Short glitch on digit 1 with a three-sample stability requirement.
    doReset();
    seen = 0;
    holdWatch(anodeFor(0), segFor(7'h79, 1'b0), 3, 1, s); seen += s;
    holdWatch(anodeFor(1), segFor(7'h12, 1'b0), 2, 1, s); seen += s;
    holdWatch(anodeFor(2), segFor(7'h24, 1'b0), 3, 1, s); seen += s;
    holdWatch(anodeFor(3), segFor(7'h78, 1'b0), 3, 1, s); seen += s;
    holdWatch(8'hFF, 8'hFF, 8, 1, s); seen += s;
    checkOutput("glitch_no_frame", seen, 0);
    finishFrame(1, 7'h02, 1'b0, 3, 1, lat);
    checkOutput("glitch_latency", lat, 6);
    checkOutput("glitch_digits", digits_b, 16'h7261);
    checkOutput("glitch_valid", valid_b, 4'hF);
    checkOutput("glitch_err", err_b, 4'h0);

    // Stale after sixteen cycles without a frame, cleared by the next frame.
    doReset();
    holdWatch(anodeFor(0), segFor(7'h79, 1'b0), 1, 2, s);
    holdWatch(anodeFor(1), segFor(7'h24, 1'b0), 1, 2, s);
    holdWatch(anodeFor(2), segFor(7'h30, 1'b0), 1, 2, s);
    finishFrame(3, 7'h19, 1'b0, 1, 2, lat);
    checkOutput("timeout_latency", lat, 4);
    checkOutput("timeout_fresh_stale", stale_c, 1'b0);
    checkOutput("timeout_fresh_valid", valid_c, 4'hF);
    for (int k = 1; k <= 16; k++) begin
      @(negedge sysclock);
      if (k == 15) begin
        checkOutput("timeout_c15_stale", stale_c, 1'b0);
        checkOutput("timeout_c15_valid", valid_c, 4'hF);
      end
      if (k == 16) begin
        checkOutput("timeout_c16_stale", stale_c, 1'b1);
        checkOutput("timeout_c16_valid", valid_c, 4'h0);
        checkOutput("timeout_c16_digits", digits_c, 16'h4321);
      end
    end
    holdWatch(anodeFor(0), segFor(7'h40, 1'b0), 1, 2, s);
    holdWatch(anodeFor(1), segFor(7'h40, 1'b0), 1, 2, s);
    holdWatch(anodeFor(2), segFor(7'h78, 1'b0), 1, 2, s);
    finishFrame(3, 7'h24, 1'b0, 1, 2, lat);
    checkOutput("timeout_recover_latency", lat, 4);
    checkOutput("timeout_recover_stale", stale_c, 1'b0);
    checkOutput("timeout_recover_valid", valid_c, 4'hF);
    checkOutput("timeout_recover_digits", digits_c, 16'h2700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
